// File: rtl/proc_selftest_pkg.sv
// Purpose : shared types for the MIPS core self-test sequencer (entry kinds, FSM states, table entry).
// Latency : n/a (types only).
// Backpressure: n/a.
package proc_selftest_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CYC_W  = 16;

  // Encoding matches the cfg_kind port directly.
  typedef enum logic [1:0] {
    K_END   = 2'b00,
    K_PROG  = 2'b01,
    K_CHECK = 2'b10,
    K_RSVD  = 2'b11
  } kind_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRST,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  // Default-width table entry; the sequencer builds an equivalent type at its own widths.
  typedef struct packed {
    kind_t                 kind;
    logic [DEF_CYC_W-1:0]  wait_cyc;
    logic [DEF_DATA_W-1:0] value;
  } entry_t;

endpackage

// File: rtl/proc_selftest_seq_table.sv
// Purpose : DEPTH-entry self-test program table, register array, not reset (contents undefined at power-up).
// Latency : write lands on the next clk edge; read is combinational from rd_idx.
// Backpressure: none; the caller gates we.
// Ports   : clk; we/wr_idx/wr_ent write port; rd_idx/rd_ent read port.
module selftest_table
  import proc_selftest_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  IDX_W = $clog2(DEPTH),
  parameter type ent_t = entry_t
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  ent_t             wr_ent,
  input  logic [IDX_W-1:0] rd_idx,
  output ent_t             rd_ent
);

  ent_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_ent;
    end
  end

  assign rd_ent = mem[rd_idx];

endmodule

// File: rtl/proc_selftest_seq.sv
// Purpose : self-test sequencer; walks a PROG/CHECK table, owns core reset + start PC, tallies pass/fail.
// Latency : start->FETCH 1 cycle; PROG = 1+RST_CYCLES+W cycles; CHECK = 1+W+1 cycles; done 1 cycle after END fetch.
// Backpressure: none; start and cfg_we are ignored while busy.
// Ports   : CLK, Reset_L (async, active-low); start; cfg_* table write; proc_dmem_out from core;
//           proc_reset_l/proc_start_pc to core; busy/done/all_passed, pass/fail counts, fail_valid/idx/actual.
module proc_selftest_seq
  import proc_selftest_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int DEPTH      = 16,
  parameter  int CYC_W      = 16,
  parameter  int RST_CYCLES = 1,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [1:0]        cfg_kind,
  input  logic [CYC_W-1:0]  cfg_wait,
  input  logic [DATA_W-1:0] cfg_value,
  input  logic [DATA_W-1:0] proc_dmem_out,
  output logic              proc_reset_l,
  output logic [DATA_W-1:0] proc_start_pc,
  output logic              busy,
  output logic              done,
  output logic              all_passed,
  output logic [IDX_W:0]    pass_count,
  output logic [IDX_W:0]    fail_count,
  output logic              fail_valid,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_actual
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    kind_t             kind;
    logic [CYC_W-1:0]  wait_cyc;
    logic [DATA_W-1:0] value;
  } ent_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              idx_end;   // set when advancing past the last entry: next fetch acts as END
  kind_t             cur_kind;
  logic [CYC_W-1:0]  cur_wait;
  logic [DATA_W-1:0] cur_value;
  logic [CYC_W-1:0]  wait_cnt;
  logic [RST_W-1:0]  rst_cnt;

  ent_t  wr_ent;
  ent_t  rd_ent;
  kind_t f_kind;
  logic  last_idx;

  assign wr_ent   = '{kind: kind_t'(cfg_kind), wait_cyc: cfg_wait, value: cfg_value};
  assign f_kind   = idx_end ? K_END : rd_ent.kind;
  assign last_idx = (idx == IDX_W'(DEPTH - 1));

  selftest_table #(
    .DEPTH (DEPTH),
    .ent_t (ent_t)
  ) u_table (
    .clk    (CLK),
    .we     (cfg_we && !busy),
    .wr_idx (cfg_addr),
    .wr_ent (wr_ent),
    .rd_idx (idx),
    .rd_ent (rd_ent)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state         <= S_IDLE;
      idx           <= '0;
      idx_end       <= 1'b0;
      cur_kind      <= K_END;
      cur_wait      <= '0;
      cur_value     <= '0;
      wait_cnt      <= '0;
      rst_cnt       <= '0;
      proc_reset_l  <= 1'b0;
      proc_start_pc <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      all_passed    <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      fail_valid    <= 1'b0;
      fail_idx      <= '0;
      fail_actual   <= '0;
    end else begin
      fail_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_FETCH;
            idx          <= '0;
            idx_end      <= 1'b0;
            pass_count   <= '0;
            fail_count   <= '0;
            done         <= 1'b0;
            all_passed   <= 1'b0;
            fail_idx     <= '0;
            busy         <= 1'b1;
            // Core stays held until the first PROG entry of the new run.
            proc_reset_l <= 1'b0;
          end
        end

        S_FETCH: begin
          cur_kind  <= f_kind;
          cur_wait  <= rd_ent.wait_cyc;
          cur_value <= rd_ent.value;
          case (f_kind)
            K_PROG: begin
              proc_start_pc <= rd_ent.value;
              proc_reset_l  <= 1'b0;
              rst_cnt       <= RST_W'(RST_CYCLES);
              state         <= S_PRST;
            end
            K_CHECK: begin
              wait_cnt <= rd_ent.wait_cyc;
              state    <= (rd_ent.wait_cyc == '0) ? S_CMP : S_WAIT;
            end
            default: begin
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              all_passed <= (fail_count == '0) && (pass_count != '0);
            end
          endcase
        end

        S_PRST: begin
          if (rst_cnt == RST_W'(1)) begin
            proc_reset_l <= 1'b1;
            wait_cnt     <= cur_wait;
            if (cur_wait == '0) begin
              // Zero wait: skip WAIT so the next fetch lands right after release.
              state <= S_FETCH;
              if (last_idx) idx_end <= 1'b1;
              else          idx     <= idx + IDX_W'(1);
            end else begin
              state <= S_WAIT;
            end
          end else begin
            rst_cnt <= rst_cnt - RST_W'(1);
          end
        end

        S_WAIT: begin
          if (wait_cnt == CYC_W'(1)) begin
            if (cur_kind == K_PROG) begin
              state <= S_FETCH;
              if (last_idx) idx_end <= 1'b1;
              else          idx     <= idx + IDX_W'(1);
            end else begin
              state <= S_CMP;
            end
          end else begin
            wait_cnt <= wait_cnt - CYC_W'(1);
          end
        end

        S_CMP: begin
          if (proc_dmem_out == cur_value) begin
            pass_count <= pass_count + CNT_W'(1);
          end else begin
            fail_count  <= fail_count + CNT_W'(1);
            fail_valid  <= 1'b1;
            fail_idx    <= idx;
            fail_actual <= proc_dmem_out;
          end
          state <= S_FETCH;
          if (last_idx) idx_end <= 1'b1;
          else          idx     <= idx + IDX_W'(1);
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_selftest_seq.sv
module tb_proc_selftest_seq;
  import proc_selftest_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int CYC_W  = 16;

  logic              CLK = 1'b0;
  logic              Reset_L = 1'b0;
  logic              start = 1'b0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_addr = '0;
  logic [1:0]        cfg_kind = '0;
  logic [CYC_W-1:0]  cfg_wait = '0;
  logic [DATA_W-1:0] cfg_value = '0;
  logic [DATA_W-1:0] proc_dmem_out;
  logic              proc_reset_l;
  logic [DATA_W-1:0] proc_start_pc;
  logic              busy, done, all_passed, fail_valid;
  logic [IDX_W:0]    pass_count, fail_count;
  logic [IDX_W-1:0]  fail_idx;
  logic [DATA_W-1:0] fail_actual;

  int checks = 0;
  int failures = 0;

  proc_selftest_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CYC_W(CYC_W), .RST_CYCLES(1)
  ) dut (
    .CLK(CLK), .Reset_L(Reset_L), .start(start),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_kind(cfg_kind),
    .cfg_wait(cfg_wait), .cfg_value(cfg_value),
    .proc_dmem_out(proc_dmem_out),
    .proc_reset_l(proc_reset_l), .proc_start_pc(proc_start_pc),
    .busy(busy), .done(done), .all_passed(all_passed),
    .pass_count(pass_count), .fail_count(fail_count),
    .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_actual(fail_actual)
  );

  always #5 CLK = ~CLK;

  // Core model: cycles since release; either counts (start_pc + cycles) or
  // produces a fixed result once model_lat cycles have elapsed.
  int unsigned core_cyc = 0;
  bit          model_count = 1'b0;
  logic [31:0] model_res = '0;
  int unsigned model_lat = 0;

  always @(posedge CLK) begin
    if (!proc_reset_l) core_cyc <= 0;
    else               core_cyc <= core_cyc + 1;
  end

  assign proc_dmem_out = !proc_reset_l ? 32'h0 :
                         model_count   ? proc_start_pc + core_cyc :
                         (core_cyc >= model_lat) ? model_res : 32'h0BAD_0BAD;

  int cyc = 0;
  int fv_cnt = 0;
  int fv_cyc = 0;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (fail_valid) begin
      fv_cnt <= fv_cnt + 1;
      fv_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input logic [1:0] k, input int w, input logic [31:0] v);
    cfg_addr  = IDX_W'(a);
    cfg_kind  = k;
    cfg_wait  = CYC_W'(w);
    cfg_value = v;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 4000) begin
      tick();
      lat++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  // Pulses start; s = cycle stamp of the first FETCH; lat = cycles from that FETCH to done.
  task automatic run(output int s, output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    wait_done(lat);
  endtask

  initial begin
    int s, lat, lat2, fv0;

    // ---- reset state ----
    tick(3);
    chk("rst_proc_reset_l", 64'(proc_reset_l), 64'd0);
    chk("rst_start_pc", 64'(proc_start_pc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_all_passed", 64'(all_passed), 64'd0);
    chk("rst_pass_count", 64'(pass_count), 64'd0);
    chk("rst_fail_count", 64'(fail_count), 64'd0);
    chk("rst_fail_valid", 64'(fail_valid), 64'd0);
    Reset_L = 1'b1;
    tick();

    // ---- single-program regression ----
    wr(0, 2'b01, 0, 32'h0);
    wr(1, 2'b10, 46, 32'd120);
    wr(2, 2'b00, 0, 32'h0);
    model_count = 1'b0; model_res = 32'd120; model_lat = 40;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_fetch", 64'(busy), 64'd1);
    tick();
    chk("t1_rst_low_prst", 64'(proc_reset_l), 64'd0);
    tick();
    chk("t1_rst_released", 64'(proc_reset_l), 64'd1);
    chk("t1_start_pc", 64'(proc_start_pc), 64'h0);
    wait_done(lat);
    chk("t1_latency", 64'(lat + 2), 64'd51);
    chk("t1_pass", 64'(pass_count), 64'd1);
    chk("t1_fail", 64'(fail_count), 64'd0);
    chk("t1_all_passed", 64'(all_passed), 64'd1);
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_core_running", 64'(proc_reset_l), 64'd1);

    // ---- mismatch ----
    wr(0, 2'b01, 0, 32'h100);
    wr(1, 2'b10, 5, 32'hfeedbeef);
    wr(2, 2'b00, 0, 32'h0);
    model_res = 32'hfeedb48f; model_lat = 0;
    fv0 = fv_cnt;
    run(s, lat);
    chk("t2_fv_pulses", 64'(fv_cnt - fv0), 64'd1);
    chk("t2_fail_idx", 64'(fail_idx), 64'd1);
    chk("t2_fail_actual", 64'(fail_actual), 64'hfeedb48f);
    chk("t2_all_passed", 64'(all_passed), 64'd0);
    chk("t2_fail_count", 64'(fail_count), 64'd1);
    chk("t2_pass_count", 64'(pass_count), 64'd0);

    // ---- back-to-back checks; entry 5 expects a neighbouring cycle's value ----
    model_count = 1'b1;
    wr(0, 2'b01, 0, 32'hA0);
    wr(1, 2'b10, 29, 32'hBE);
    for (int n = 2; n <= 12; n++) begin
      wr(n, 2'b10, 0, (n == 5) ? 32'hC7 : 32'(32'hBE + 2 * (n - 1)));
    end
    wr(13, 2'b00, 0, 32'h0);
    run(s, lat);
    chk("t3_pass", 64'(pass_count), 64'd11);
    chk("t3_fail", 64'(fail_count), 64'd1);
    chk("t3_sum", 64'(pass_count + fail_count), 64'd12);
    chk("t3_fail_idx", 64'(fail_idx), 64'd5);
    chk("t3_fail_actual", 64'(fail_actual), 64'hC6);
    chk("t3_fv_cycle", 64'(fv_cyc - s), 64'd41);
    chk("t3_latency", 64'(lat), 64'd56);

    // ---- reset mid-WAIT ----
    wr(0, 2'b01, 20, 32'h40);
    wr(1, 2'b10, 3, 32'h58);
    wr(2, 2'b00, 0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(8);
    chk("t5_in_wait_busy", 64'(busy), 64'd1);
    chk("t5_in_wait_released", 64'(proc_reset_l), 64'd1);
    Reset_L = 1'b0;
    #1;
    chk("t5_rst_proc_reset_l", 64'(proc_reset_l), 64'd0);
    chk("t5_rst_start_pc", 64'(proc_start_pc), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_counts", 64'({pass_count, fail_count}), 64'd0);
    chk("t5_rst_fail_idx", 64'(fail_idx), 64'd0);
    chk("t5_rst_fail_actual", 64'(fail_actual), 64'd0);
    tick(2);
    Reset_L = 1'b1;
    tick();
    run(s, lat);
    chk("t5_rerun_latency", 64'(lat), 64'd28);
    chk("t5_rerun_pass", 64'(pass_count), 64'd1);
    chk("t5_rerun_all_passed", 64'(all_passed), 64'd1);
    run(s, lat2);
    chk("t5_again_latency", 64'(lat2), 64'd28);
    chk("t5_again_pass", 64'(pass_count), 64'd1);
    chk("t5_again_fail", 64'(fail_count), 64'd0);

    // ---- config / start guard while busy ----
    model_count = 1'b0; model_res = 32'h12345678; model_lat = 0;
    wr(0, 2'b01, 0, 32'h0);
    wr(1, 2'b10, 30, 32'h12345678);
    wr(2, 2'b00, 0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(10);
    wr(1, 2'b10, 0, 32'h12345679);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr(2, 2'b10, 0, 32'h0);
    wait_done(lat);
    chk("t6_latency", 64'(lat + 13), 64'd35);
    chk("t6_pass", 64'(pass_count), 64'd1);
    chk("t6_fail", 64'(fail_count), 64'd0);
    run(s, lat);
    chk("t6_table_kept_latency", 64'(lat), 64'd35);
    chk("t6_table_kept_pass", 64'(pass_count), 64'd1);
    chk("t6_table_kept_fail", 64'(fail_count), 64'd0);

    // ---- full table, no END ----
    model_res = 32'h5A5A;
    wr(0, 2'b01, 0, 32'h200);
    for (int n = 1; n < DEPTH; n++) begin
      wr(n, 2'b10, 0, 32'h5A5A);
    end
    run(s, lat);
    chk("t4_latency", 64'(lat), 64'd33);
    chk("t4_pass", 64'(pass_count), 64'd15);
    chk("t4_fail", 64'(fail_count), 64'd0);
    chk("t4_all_passed", 64'(all_passed), 64'd1);
    tick(20);
    chk("t4_still_done", 64'(done), 64'd1);
    chk("t4_not_busy", 64'(busy), 64'd0);
    chk("t4_no_wrap", 64'(pass_count), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
